// File: rtl/multi_freq_meter.sv
// Multi-channel equal-precision frequency meter with a shared sequential multiply/divide unit.
// Optional FM_NOSIG_EN: channels that never opened or timed out report 0 with freq_nosig set.
module multi_freq_meter #(
  parameter int CH       = 4,
  parameter int SYS_FREQ = 48_000_000,
  parameter int PRE_CYC  = 12_000_000,
  parameter int GATE_CYC = 48_000_000,
  parameter int CNT_W    = 32,
  parameter int FREQ_W   = 32
) (
  input  logic                                  sys_clk,
  input  logic                                  sys_rst_n,
  input  logic [CH-1:0]                         sig_in,
  output logic [FREQ_W-1:0]                     freq_out,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] freq_ch,
  output logic                                  freq_valid,
  input  logic                                  freq_ready,
  output logic                                  freq_nosig,
  output logic                                  busy
);

  localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1;
  localparam int CYC_MAX = (PRE_CYC > GATE_CYC) ? PRE_CYC : GATE_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int STEP_W  = $clog2(2 * CNT_W + 2);
  localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(2 * CNT_W + 1);
  localparam logic [2*CNT_W-1:0]   REF_2W    = (2 * CNT_W)'(SYS_FREQ);
  localparam logic [2*CNT_W:0]     FREQ_LIM  = (2 * CNT_W + 1)'(1) << FREQ_W;

  typedef enum logic [2:0] {S_PRE, S_GATE, S_DRAIN, S_CALC, S_OUT} state_t;

  state_t                     state_q, state_d;
  logic [CYC_W-1:0]           cnt_q, cnt_d;
  logic [CH-1:0]              sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [CH-1:0]              rise_q, rise_d;
  logic [CH-1:0]              open_q, open_d, closed_q, closed_d;
`ifdef FM_NOSIG_EN
  logic [CH-1:0]              forced_q, forced_d;
`endif
  logic [CNT_W-1:0]           x_q [CH];
  logic [CNT_W-1:0]           x_d [CH];
  logic [CNT_W-1:0]           y_q [CH];
  logic [CNT_W-1:0]           y_d [CH];
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [STEP_W-1:0]          step_q, step_d;
  logic [2*CNT_W-1:0]         quo_q, quo_d;
  logic [CNT_W-1:0]           rem_q, rem_d;
  logic [FREQ_W-1:0]          freq_out_q, freq_out_d;
  logic                       nosig_q, nosig_d;

  logic                       timeout, all_done, skip_div, last_ch, sat;
  logic [CNT_W-1:0]           x_sel, y_sel;
  logic [CNT_W:0]             rem_sh;

  assign timeout  = (state_q == S_DRAIN) && (cnt_q == CYC_W'(GATE_CYC - 1));
  assign all_done = &(~open_q | closed_q);
  assign last_ch  = (ch_q == CH_W'(CH - 1));
  assign x_sel    = x_q[ch_q];
  assign y_sel    = y_q[ch_q];
  assign sat      = ({1'b0, quo_q} >= FREQ_LIM);
  assign rem_sh   = {rem_q, quo_q[2*CNT_W-1]};
`ifdef FM_NOSIG_EN
  assign skip_div = ~open_q[ch_q] | forced_q[ch_q];
`else
  assign skip_div = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state_q <= S_PRE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PRE:   if (cnt_q == CYC_W'(PRE_CYC - 1)) state_d = S_GATE;
      S_GATE:  if (cnt_q == CYC_W'(GATE_CYC - 1)) state_d = S_DRAIN;
      S_DRAIN: if (all_done || timeout) state_d = S_CALC;
      S_CALC:  if ((step_q == '0 && skip_div) || step_q == STEP_LAST) state_d = S_OUT;
      S_OUT:   if (freq_ready) state_d = last_ch ? S_PRE : S_CALC;
      default: state_d = S_PRE;
    endcase
  end

  // Handshake: a result transfers on a cycle where freq_valid && freq_ready; outputs hold until then.
  always_comb begin
    busy       = (state_q != S_PRE);
    freq_valid = (state_q == S_OUT);
    freq_out   = freq_out_q;
    freq_ch    = ch_q;
    freq_nosig = nosig_q;
  end

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    rise_d  = sync2_q & ~sync3_q;
    cnt_d   = '0;
    if ((state_q inside {S_PRE, S_GATE, S_DRAIN}) && state_d == state_q) cnt_d = cnt_q + CYC_W'(1);
    x_d      = x_q;
    y_d      = y_q;
    open_d   = open_q;
    closed_d = closed_q;
`ifdef FM_NOSIG_EN
    forced_d = forced_q;
`endif
    for (int i = 0; i < CH; i++) begin
      if (state_q == S_PRE) begin
        x_d[i]      = '0;
        y_d[i]      = '0;
        open_d[i]   = 1'b0;
        closed_d[i] = 1'b0;
`ifdef FM_NOSIG_EN
        forced_d[i] = 1'b0;
`endif
      end else if (open_q[i] && !closed_q[i]) begin
        if (y_q[i] != '1) y_d[i] = y_q[i] + CNT_W'(1);
        if (rise_q[i]) begin
          if (x_q[i] != '1) x_d[i] = x_q[i] + CNT_W'(1);
          if (state_q == S_DRAIN) closed_d[i] = 1'b1;
        end else if (timeout) begin
          closed_d[i] = 1'b1;
`ifdef FM_NOSIG_EN
          forced_d[i] = 1'b1;
`endif
        end
      end else if (state_q == S_GATE && rise_q[i]) begin
        open_d[i] = 1'b1;
      end
    end

    ch_d       = ch_q;
    step_d     = step_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    freq_out_d = freq_out_q;
    nosig_d    = nosig_q;
    if (state_q == S_OUT && freq_ready) ch_d = last_ch ? '0 : ch_q + CH_W'(1);
    if (state_q == S_CALC) begin
      step_d = step_q + STEP_W'(1);
      if (step_q == '0) begin
        if (skip_div) begin
          freq_out_d = '0;
          nosig_d    = 1'b1;
          step_d     = '0;
        end else begin
          quo_d = {{CNT_W{1'b0}}, x_sel} * REF_2W;
          rem_d = '0;
        end
      end else if (step_q == STEP_LAST) begin
        nosig_d = 1'b0;
        step_d  = '0;
        if (y_sel == '0) freq_out_d = '0;
        else if (sat)    freq_out_d = '1;
        else             freq_out_d = quo_q[FREQ_W-1:0];
      end else if (rem_sh >= {1'b0, y_sel}) begin
        // Restoring divide: quotient bits shift in as dividend bits shift out of quo_q.
        rem_d = rem_sh[CNT_W-1:0] - y_sel;
        quo_d = {quo_q[2*CNT_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[CNT_W-1:0];
        quo_d = {quo_q[2*CNT_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync3_q    <= '0;
      rise_q     <= '0;
      open_q     <= '0;
      closed_q   <= '0;
`ifdef FM_NOSIG_EN
      forced_q   <= '0;
`endif
      for (int i = 0; i < CH; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      ch_q       <= '0;
      step_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      freq_out_q <= '0;
      nosig_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      rise_q     <= rise_d;
      open_q     <= open_d;
      closed_q   <= closed_d;
`ifdef FM_NOSIG_EN
      forced_q   <= forced_d;
`endif
      for (int i = 0; i < CH; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      ch_q       <= ch_d;
      step_q     <= step_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      freq_out_q <= freq_out_d;
      nosig_q    <= nosig_d;
    end
  end

endmodule

// File: tb/tb_multi_freq_meter.sv
// Self-checking bench for multi_freq_meter: square-wave generators, an event-level gate model,
// and per-scenario tasks with inline checks.
module tb_multi_freq_meter;
  localparam int CH       = 4;
  localparam int SYS_FREQ = 48_000_000;
  localparam int PRE_CYC  = 16;
  localparam int GATE_CYC = 1000;
  localparam int CALC_GAP = 2 * 32 + 3;
`ifdef FM_NOSIG_EN
  localparam logic NOSIG = 1'b1;
`else
  localparam logic NOSIG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  sig_in = '0;
  logic        freq_ready = 1'b0;
  logic [31:0] freq_out;
  logic [1:0]  freq_ch;
  logic        freq_valid, freq_nosig, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int per_cfg[4] = '{0, 0, 0, 0};
  int phase_cfg[4] = '{0, 0, 0, 0};
  int cfg_gen = 0;
  int stop_cyc = 32'h7fff_ffff;
  int ph[4] = '{0, 0, 0, 0};
  int last_gen = 0;
  int rise0_q[$];

  logic [31:0] got_out[4];
  int          got_ch[4];
  logic        got_nosig[4];
  int          got_cyc[4];
  int          got_n;

  multi_freq_meter #(
    .CH(CH), .SYS_FREQ(SYS_FREQ), .PRE_CYC(PRE_CYC), .GATE_CYC(GATE_CYC), .CNT_W(32), .FREQ_W(32)
  ) dut (
    .sys_clk(clk), .sys_rst_n(sys_rst_n), .sig_in(sig_in), .freq_out(freq_out), .freq_ch(freq_ch),
    .freq_valid(freq_valid), .freq_ready(freq_ready), .freq_nosig(freq_nosig), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Generators: a value set here is first sampled at posedge cyc+1; rises of ch0 are logged by that index.
  initial forever begin
    @(posedge clk);
    #1;
    if (last_gen != cfg_gen) begin
      last_gen = cfg_gen;
      rise0_q.delete();
      for (int i = 0; i < 4; i++) ph[i] = phase_cfg[i];
    end
    for (int i = 0; i < 4; i++) begin
      logic nv;
      if (per_cfg[i] == 0) nv = 1'b0;
      else begin
        ph[i] = (ph[i] + 1) % per_cfg[i];
        nv = (ph[i] < per_cfg[i] / 2);
      end
      if (i == 0 && cyc + 1 >= stop_cyc) nv = 1'b0;
      if (i == 0 && nv && !sig_in[0]) rise0_q.push_back(cyc + 1);
      sig_in[i] = nv;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic start_round(input int p0, input int p1, input int p2, input int p3);
    sys_rst_n = 1'b0;
    per_cfg = '{p0, p1, p2, p3};
    for (int i = 0; i < 4; i++) phase_cfg[i] = (per_cfg[i] > 0) ? $urandom_range(0, per_cfg[i] - 1) : 0;
    stop_cyc = 32'h7fff_ffff;
    cfg_gen++;
    repeat (3) @(posedge clk);
    #1 sys_rst_n = 1'b1;
  endtask

  task automatic collect_round(input bit rnd_ready, input int budget);
    got_n = 0;
    for (int c = 0; c < budget && got_n < 4; c++) begin
      @(negedge clk);
      freq_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (freq_valid && freq_ready) begin
        got_out[got_n]   = freq_out;
        got_ch[got_n]    = int'(freq_ch);
        got_nosig[got_n] = freq_nosig;
        got_cyc[got_n]   = cyc;
        got_n++;
      end
    end
    freq_ready = 1'b1;
  endtask

  task automatic wait_busy(output int a, output bit ok);
    ok = 1'b0;
    a = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1'b1;
        a = cyc;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    freq_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (freq_out !== 32'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", freq_out); end
    checks++; if (freq_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d expected 0", freq_ch); end
    checks++; if (freq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", freq_valid); end
    checks++; if (freq_nosig !== 1'b0) begin errors++; $display("FAIL reset_nosig: got %0b expected 0", freq_nosig); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    sys_rst_n = 1'b1;
    repeat (PRE_CYC - 2) @(negedge clk);
    checks++; if (busy !== 1'b0 || freq_valid !== 1'b0) begin
      errors++; $display("FAIL pre_idle: busy=%0b valid=%0b expected 0 0", busy, freq_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_v[4];
    exp_v = '{32'd4_800_000, 32'd6_857_142, 32'd24_000_000, 32'd0};
    freq_ready = 1'b1;
    start_round(10, 7, 2, 0);
    collect_round(1'b0, 4000);
    checks++; if (got_n !== 4) begin errors++; $display("FAIL basic_count: got %0d results expected 4", got_n); end
    for (int k = 0; k < got_n; k++) begin
      checks++; if (got_ch[k] !== k) begin errors++; $display("FAIL basic_ch%0d: got %0d expected %0d", k, got_ch[k], k); end
      checks++; if (got_out[k] !== exp_v[k]) begin errors++; $display("FAIL basic_out%0d: got %0d expected %0d", k, got_out[k], exp_v[k]); end
      checks++; if (got_nosig[k] !== ((k == 3) ? NOSIG : 1'b0)) begin
        errors++; $display("FAIL basic_nosig%0d: got %0b expected %0b", k, got_nosig[k], (k == 3) ? NOSIG : 1'b0);
      end
    end
    if (got_n == 4) begin
      checks++; if (got_cyc[1] - got_cyc[0] !== CALC_GAP) begin
        errors++; $display("FAIL basic_gap01: got %0d expected %0d", got_cyc[1] - got_cyc[0], CALC_GAP);
      end
      checks++; if (got_cyc[2] - got_cyc[1] !== CALC_GAP) begin
        errors++; $display("FAIL basic_gap12: got %0d expected %0d", got_cyc[2] - got_cyc[1], CALC_GAP);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] o;
    logic [1:0]  c0;
    bit          seen;
    logic [31:0] exp_v[4];
    exp_v = '{32'd4_800_000, 32'd6_857_142, 32'd24_000_000, 32'd0};
    freq_ready = 1'b0;
    start_round(10, 7, 2, 0);
    seen = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(negedge clk);
      seen = freq_valid;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_valid_timeout: got no valid expected valid"); end
    o = freq_out;
    c0 = freq_ch;
    checks++; if (o !== 32'd4_800_000 || c0 !== 2'd0) begin
      errors++; $display("FAIL bp_first: got ch%0d %0d expected ch0 4800000", c0, o);
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++;
      if (freq_valid !== 1'b1 || freq_out !== o || freq_ch !== 2'd0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%0b out=%0d ch=%0d busy=%0b expected 1 %0d 0 1", c, freq_valid, freq_out, freq_ch, busy, o);
      end
    end
    collect_round(1'b0, 4000);
    checks++; if (got_n !== 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", got_n); end
    for (int k = 0; k < got_n; k++) begin
      checks++; if (got_ch[k] !== k || got_out[k] !== exp_v[k]) begin
        errors++; $display("FAIL bp_res%0d: got ch%0d %0d expected ch%0d %0d", k, got_ch[k], got_out[k], k, exp_v[k]);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int a;
    bit ok;
    logic [31:0] exp_v[4];
    exp_v = '{32'd4_800_000, 32'd6_857_142, 32'd24_000_000, 32'd0};
    freq_ready = 1'b1;
    start_round(10, 7, 2, 0);
    wait_busy(a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_busy_timeout: got busy=0 expected 1"); end
    while (cyc < a + GATE_CYC + 1) @(negedge clk);
    sys_rst_n = 1'b0;
    @(negedge clk);
    checks++; if (freq_out !== 32'd0 || freq_ch !== 2'd0 || freq_valid !== 1'b0 || freq_nosig !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_outputs: got out=%0d ch=%0d v=%0b ns=%0b busy=%0b expected all 0", freq_out, freq_ch, freq_valid, freq_nosig, busy);
    end
    sys_rst_n = 1'b1;
    collect_round(1'b0, 4000);
    checks++; if (got_n !== 4) begin errors++; $display("FAIL rst_count: got %0d expected 4", got_n); end
    for (int k = 0; k < got_n; k++) begin
      checks++; if (got_ch[k] !== k || got_out[k] !== exp_v[k]) begin
        errors++; $display("FAIL rst_res%0d: got ch%0d %0d expected ch%0d %0d", k, got_ch[k], got_out[k], k, exp_v[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int a, popen, pclose, yend, exp_cyc;
    bit ok, forced;
    longint xs;
    logic [31:0] exp0;
    logic exp_ns;
    freq_ready = 1'b1;
    start_round(10, 0, 0, 0);
    wait_busy(a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_busy_timeout: got busy=0 expected 1"); end
    // The signal goes quiet late in the gate so no edge can close the window in DRAIN.
    stop_cyc = a + 990;
    collect_round(1'b0, 5000);
    popen = -1;
    pclose = -1;
    xs = 0;
    foreach (rise0_q[j]) begin
      int e;
      e = rise0_q[j] + 3;
      if (popen < 0) begin
        if (e >= a + 1 && e <= a + GATE_CYC) popen = e;
      end else if (pclose < 0 && e <= a + 2 * GATE_CYC) begin
        xs++;
        if (e > a + GATE_CYC) pclose = e;
      end
    end
    forced = (popen >= 0) && (pclose < 0);
    yend = forced ? a + 2 * GATE_CYC : pclose;
    if (popen < 0 || (NOSIG && forced)) exp0 = 32'd0;
    else exp0 = 32'((longint'(SYS_FREQ) * xs) / longint'(yend - popen));
    exp_ns = NOSIG && (popen < 0 || forced);
    exp_cyc = a + 2 * GATE_CYC + ((NOSIG && forced) ? 1 : CALC_GAP - 1);
    checks++; if (got_n !== 4) begin errors++; $display("FAIL to_count: got %0d expected 4", got_n); end
    if (got_n > 0) begin
      checks++; if (got_out[0] !== exp0) begin errors++; $display("FAIL to_out0: got %0d expected %0d", got_out[0], exp0); end
      checks++; if (got_nosig[0] !== exp_ns) begin errors++; $display("FAIL to_nosig0: got %0b expected %0b", got_nosig[0], exp_ns); end
      checks++; if (got_cyc[0] !== exp_cyc) begin errors++; $display("FAIL to_latency: got cycle %0d expected %0d", got_cyc[0], exp_cyc); end
    end
    for (int k = 1; k < got_n; k++) begin
      checks++; if (got_out[k] !== 32'd0 || got_nosig[k] !== NOSIG) begin
        errors++; $display("FAIL to_idle%0d: got %0d ns=%0b expected 0 ns=%0b", k, got_out[k], got_nosig[k], NOSIG);
      end
    end
  endtask

  task automatic test_random();
    int p[4];
    logic [31:0] e;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) p[i] = $urandom_range(2, 40);
      start_round(p[0], p[1], p[2], p[3]);
      collect_round(1'b1, 8000);
      checks++; if (got_n !== 4) begin errors++; $display("FAIL rnd%0d_count: got %0d expected 4", r, got_n); end
      for (int k = 0; k < got_n; k++) begin
        e = 32'(SYS_FREQ / p[k]);
        checks++; if (got_ch[k] !== k || got_out[k] !== e || got_nosig[k] !== 1'b0) begin
          errors++;
          $display("FAIL rnd%0d_ch%0d: got ch%0d %0d ns=%0b expected ch%0d %0d ns=0 (period %0d)", r, k, got_ch[k], got_out[k], got_nosig[k], k, e, p[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_drain();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
